// File: rtl/pc_seq.sv
// pc_seq -- program-counter sequencer for the multi-program core.
//
// Holds the instruction fetch address and launches programs from a
// parameter entry table, one program per start pulse, cycling through the
// table in order. While a program runs the PC advances, branches
// (unconditionally or on the ALU z/lt flags), calls and returns through a
// small hardware return-address stack. A stack overflow/underflow ends the
// program and raises a sticky stack_err flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      launch the next program (only acted on in IDLE or DONE)
//   stall      hold PC and stack this cycle (RUN only)
//   halt       end the current program (RUN only)
//   br_mode    0 NEXT, 1 BA, 2 BL, 3 BGE, 4 BE, 5 BNE, 6 CALL, 7 RET
//   z, lt      ALU flags, sampled with br_mode
//   bamt       signed branch/call offset
//   PC         current fetch address
//   prog_id    index of the program currently/last loaded
//   running    high while a program runs
//   done       high once a program has ended
//   stack_err  sticky return-stack fault flag
module pc_seq #(
    parameter int                        PC_W        = 8,
    parameter int                        OFF_W       = 8,
    parameter int                        NUM_PROG    = 3,
    parameter logic [NUM_PROG*PC_W-1:0]  ENTRY       = {8'd44, 8'd25, 8'd0},
    parameter int                        STACK_DEPTH = 4,
    localparam int                       PID_W       = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic [2:0]       br_mode,
    input  logic             z,
    input  logic             lt,
    input  logic [OFF_W-1:0] bamt,
    output logic [PC_W-1:0]  PC,
    output logic [PID_W-1:0] prog_id,
    output logic             running,
    output logic             done,
    output logic             stack_err
);

    // sp counts 0..STACK_DEPTH inclusive, so it needs one more code than the index.
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] BR_NEXT = 3'd0;
    localparam logic [2:0] BR_BA   = 3'd1;
    localparam logic [2:0] BR_BL   = 3'd2;
    localparam logic [2:0] BR_BGE  = 3'd3;
    localparam logic [2:0] BR_BE   = 3'd4;
    localparam logic [2:0] BR_BNE  = 3'd5;
    localparam logic [2:0] BR_CALL = 3'd6;
    localparam logic [2:0] BR_RET  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [PID_W-1:0] pid_reg;
    logic [PID_W-1:0] ptr_reg;
    logic [SP_W-1:0]  sp_reg;
    logic             err_reg;
    logic             running_reg;
    logic             done_reg;

    logic [PC_W-1:0]  entry_tab [NUM_PROG];
    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

    generate
        for (genvar gi = 0; gi < NUM_PROG; gi++) begin : g_entry
            assign entry_tab[gi] = ENTRY[gi*PC_W +: PC_W];
        end
    endgenerate

    logic [PC_W-1:0]  bamt_ext;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_tgt;
    logic [PC_W-1:0]  top_addr;
    logic [SP_W-1:0]  sp_dec;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [PID_W-1:0] ptr_next;
    logic             stack_full;
    logic             stack_empty;
    logic             advance;
    logic             push_en;
    logic             taken;

    // Offset is two's complement; the signed cast sign-extends to PC width.
    assign bamt_ext    = PC_W'($signed(bamt));
    assign pc_inc      = pc_reg + PC_W'(1);
    assign pc_tgt      = pc_reg + bamt_ext;
    assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_reg == '0);
    assign sp_dec      = sp_reg - SP_W'(1);
    assign push_idx    = sp_reg[IDX_W-1:0];
    assign top_idx     = sp_dec[IDX_W-1:0];
    assign top_addr    = stack_mem[top_idx];
    assign ptr_next    = (ptr_reg == PID_W'(NUM_PROG - 1)) ? '0 : ptr_reg + PID_W'(1);

    // A branch/call/return only acts in RUN when neither halt nor stall wins.
    assign advance = (state_reg == S_RUN) && !halt && !stall;
    assign push_en = advance && (br_mode == BR_CALL) && !stack_full && !reset;

    always_comb begin
        taken = 1'b0;
        case (br_mode)
            BR_BA:   taken = 1'b1;
            BR_BL:   taken = lt;
            BR_BGE:  taken = !lt;
            BR_BE:   taken = z;
            BR_BNE:  taken = !z;
            default: taken = 1'b0;
        endcase
    end

    // Return-address storage; only the pointer is reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            pid_reg     <= '0;
            ptr_reg     <= '0;
            sp_reg      <= '0;
            err_reg     <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_reg      <= entry_tab[ptr_reg];
                        pid_reg     <= ptr_reg;
                        ptr_reg     <= ptr_next;
                        sp_reg      <= '0;
                        err_reg     <= 1'b0;
                        state_reg   <= S_RUN;
                        running_reg <= 1'b1;
                        done_reg    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_reg   <= S_DONE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end else if (!stall) begin
                        if ((br_mode == BR_CALL && stack_full) ||
                            (br_mode == BR_RET && stack_empty)) begin
                            // Fault: PC and stack are frozen, program ends.
                            err_reg     <= 1'b1;
                            state_reg   <= S_DONE;
                            running_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end else if (br_mode == BR_CALL) begin
                            sp_reg <= sp_reg + SP_W'(1);
                            pc_reg <= pc_tgt;
                        end else if (br_mode == BR_RET) begin
                            sp_reg <= sp_dec;
                            pc_reg <= top_addr;
                        end else begin
                            pc_reg <= taken ? pc_tgt : pc_inc;
                        end
                    end
                end
                default: begin
                    state_reg   <= S_IDLE;
                    running_reg <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign PC        = pc_reg;
    assign prog_id   = pid_reg;
    assign running   = running_reg;
    assign done      = done_reg;
    assign stack_err = err_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Table-driven bench for pc_seq with default parameters
// (PC_W=8, OFF_W=8, NUM_PROG=3, ENTRY={44,25,0}, STACK_DEPTH=4).
module tb_pc_seq;

    localparam logic [2:0] NX = 3'd0, BA = 3'd1, BL = 3'd2, BGE = 3'd3;
    localparam logic [2:0] BE = 3'd4, BNE = 3'd5, CALL = 3'd6, RET = 3'd7;

    logic       clk = 1'b0;
    logic       reset, start, stall, halt, z, lt;
    logic [2:0] br_mode;
    logic [7:0] bamt;
    logic [7:0] PC;
    logic [1:0] prog_id;
    logic       running, done, stack_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .halt      (halt),
        .br_mode   (br_mode),
        .z         (z),
        .lt        (lt),
        .bamt      (bamt),
        .PC        (PC),
        .prog_id   (prog_id),
        .running   (running),
        .done      (done),
        .stack_err (stack_err)
    );

    typedef struct {
        logic       rst, st, stl, hlt;
        logic [2:0] mode;
        logic       fz, flt;
        logic [7:0] amt;
        logic [7:0] pc;
        logic [1:0] pid;
        logic       run, dn, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic st, input logic stl, input logic hlt,
                       input logic [2:0] mode, input logic fz, input logic flt,
                       input logic [7:0] amt, input logic [7:0] pc, input logic [1:0] pid,
                       input logic run, input logic dn, input logic err);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt; v.mode = mode;
        v.fz = fz; v.flt = flt; v.amt = amt; v.pc = pc; v.pid = pid;
        v.run = run; v.dn = dn; v.err = err;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then check all outputs 1 time unit after the edge.
    task automatic apply(input vec_t v, input string tag);
        reset = v.rst; start = v.st; stall = v.stl; halt = v.hlt;
        br_mode = v.mode; z = v.fz; lt = v.flt; bamt = v.amt;
        @(posedge clk);
        #1;
        total++;
        if ({PC, prog_id, running, done, stack_err} !== {v.pc, v.pid, v.run, v.dn, v.err}) begin
            bad++;
            $display("FAIL %s: got pc=%0d pid=%0d run=%0b done=%0b err=%0b, want pc=%0d pid=%0d run=%0b done=%0b err=%0b",
                     tag, PC, prog_id, running, done, stack_err,
                     v.pc, v.pid, v.run, v.dn, v.err);
        end else begin
            $display("ok   %s: pc=%0d pid=%0d run=%0b done=%0b err=%0b",
                     tag, PC, prog_id, running, done, stack_err);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
    endtask

    initial begin
        vec_t h;
        int   part_a, part_b;

        reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
        br_mode = NX; z = 1'b0; lt = 1'b0; bamt = 8'd0;

        //   rst st stl hlt mode  z  lt bamt    | pc    pid run dn err
        // Part A: reset, first program, three NEXTs, halt.
        add(1, 0, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 0, 0, 0);
        add(1, 1, 0, 1, BA,   0, 0, 8'd7,     8'd0,   0, 0, 0, 0);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 1, 0, 0);
        add(0, 0, 0, 0, NX,   0, 0, 8'd0,     8'd1,   0, 1, 0, 0);
        add(0, 0, 0, 0, NX,   0, 0, 8'd0,     8'd2,   0, 1, 0, 0);
        add(0, 0, 0, 0, NX,   0, 0, 8'd0,     8'd3,   0, 1, 0, 0);
        add(0, 0, 0, 1, NX,   0, 0, 8'd0,     8'd3,   0, 0, 1, 0);
        part_a = vecs.size();
        // Part B: program rounds, start ignored in RUN, branches, call/return, wrap.
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd25,  1, 1, 0, 0);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd26,  1, 1, 0, 0);
        add(0, 0, 0, 1, NX,   0, 0, 8'd0,     8'd26,  1, 0, 1, 0);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd44,  2, 1, 0, 0);
        add(0, 0, 0, 1, NX,   0, 0, 8'd0,     8'd44,  2, 0, 1, 0);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 1, 0, 0);
        add(0, 0, 0, 0, BA,   0, 0, 8'd10,    8'd10,  0, 1, 0, 0);
        add(0, 0, 0, 0, BL,   0, 1, 8'hFD,    8'd7,   0, 1, 0, 0);
        add(0, 0, 0, 0, BL,   0, 0, 8'hFD,    8'd8,   0, 1, 0, 0);
        add(0, 0, 0, 0, BE,   1, 0, 8'd5,     8'd13,  0, 1, 0, 0);
        add(0, 0, 0, 0, BNE,  1, 0, 8'd5,     8'd14,  0, 1, 0, 0);
        add(0, 0, 0, 0, BGE,  0, 0, 8'd2,     8'd16,  0, 1, 0, 0);
        add(0, 0, 0, 0, BGE,  0, 1, 8'd2,     8'd17,  0, 1, 0, 0);
        add(0, 0, 0, 0, BNE,  0, 0, 8'd3,     8'd20,  0, 1, 0, 0);
        add(0, 0, 0, 0, CALL, 0, 0, 8'd30,    8'd50,  0, 1, 0, 0);
        add(0, 0, 0, 0, NX,   0, 0, 8'd0,     8'd51,  0, 1, 0, 0);
        add(0, 0, 0, 0, RET,  0, 0, 8'd0,     8'd21,  0, 1, 0, 0);
        add(0, 0, 0, 0, RET,  0, 0, 8'd0,     8'd21,  0, 0, 1, 1);
        add(0, 0, 0, 1, NX,   0, 0, 8'd0,     8'd21,  0, 0, 1, 1);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd25,  1, 1, 0, 0);
        add(0, 0, 1, 0, BA,   0, 0, 8'd10,    8'd25,  1, 1, 0, 0);
        add(0, 0, 1, 1, BA,   0, 0, 8'd10,    8'd25,  1, 0, 1, 0);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd44,  2, 1, 0, 0);
        add(0, 0, 0, 0, BA,   0, 0, 8'h80,    8'd172, 2, 1, 0, 0);
        add(0, 0, 0, 0, BA,   0, 0, 8'd83,    8'd255, 2, 1, 0, 0);
        add(0, 0, 0, 0, NX,   0, 0, 8'd0,     8'd0,   2, 1, 0, 0);
        add(0, 0, 0, 0, CALL, 0, 0, 8'd127,   8'd127, 2, 1, 0, 0);
        part_b = vecs.size();
        // Part C: start clears sp, nested call/return order, reset mid-RUN.
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 1, 0, 0);
        add(0, 0, 0, 0, CALL, 0, 0, 8'd10,    8'd10,  0, 1, 0, 0);
        add(0, 0, 0, 0, CALL, 0, 0, 8'hFC,    8'd6,   0, 1, 0, 0);
        add(0, 0, 0, 0, RET,  0, 0, 8'd0,     8'd11,  0, 1, 0, 0);
        add(0, 0, 0, 0, RET,  0, 0, 8'd0,     8'd1,   0, 1, 0, 0);
        add(0, 0, 0, 0, CALL, 0, 0, 8'd9,     8'd10,  0, 1, 0, 0);
        add(0, 0, 0, 0, CALL, 0, 0, 8'd20,    8'd30,  0, 1, 0, 0);
        add(1, 0, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 0, 0, 0);
        add(0, 0, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 0, 0, 0);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd0,   0, 1, 0, 0);
        add(0, 0, 0, 0, RET,  0, 0, 8'd0,     8'd0,   0, 0, 1, 1);
        add(0, 1, 0, 0, NX,   0, 0, 8'd0,     8'd25,  1, 1, 0, 0);

        run_range(0, part_a);

        // DONE holds PC for 5 cycles; halt and branches are ignored there.
        for (int i = 0; i < 5; i++) begin
            h = '{rst:0, st:0, stl:0, hlt:1, mode:BA, fz:0, flt:0, amt:8'd5,
                  pc:8'd3, pid:0, run:0, dn:1, err:0};
            apply(h, $sformatf("done_hold%0d", i));
        end

        run_range(part_a, part_b);

        // Three more nested CALLs fill the 4-deep stack; the fifth overflows.
        for (int i = 1; i <= 3; i++) begin
            h = '{rst:0, st:0, stl:0, hlt:0, mode:CALL, fz:0, flt:0, amt:8'd1,
                  pc:8'(127 + i), pid:2, run:1, dn:0, err:0};
            apply(h, $sformatf("nest_call%0d", i + 1));
        end
        h = '{rst:0, st:0, stl:0, hlt:0, mode:CALL, fz:0, flt:0, amt:8'd1,
              pc:8'd130, pid:2, run:0, dn:1, err:1};
        apply(h, "overflow_call5");

        run_range(part_b, vecs.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
